// File: rtl/music_box_pkg.sv
// Shared music box definitions: controller state codes, DAC sample source indices,
// DAC silence level and the sample scheduler FSM states.
package music_box_pkg;

  localparam logic [4:0] ST_DONOTHING     = 5'd1;
  localparam logic [4:0] ST_PLAYSONG0     = 5'd2;
  localparam logic [4:0] ST_PLAYSONG1     = 5'd3;
  localparam logic [4:0] ST_MAKERECORDING = 5'd4;
  localparam logic [4:0] ST_PLAYRECORDING = 5'd5;

  localparam int SRC_KEYS   = 0;
  localparam int SRC_SONG0  = 1;
  localparam int SRC_SONG1  = 2;
  localparam int SRC_RECORD = 3;

  localparam logic [11:0] DAC_MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    START,
    WAIT_DONE
  } dac_sched_state_t;

  // Which sample source is allowed to feed the DAC in a given controller state.
  function automatic logic [3:0] sourceMask(input logic [4:0] state);
    logic [3:0] mask;
    mask = '0;
    case (state)
      ST_DONOTHING, ST_MAKERECORDING: mask[SRC_KEYS]   = 1'b1;
      ST_PLAYSONG0:                   mask[SRC_SONG0]  = 1'b1;
      ST_PLAYSONG1:                   mask[SRC_SONG1]  = 1'b1;
      ST_PLAYRECORDING:               mask[SRC_RECORD] = 1'b1;
      default:                        mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sample_rate_ticker.sv
// Free-running sample-rate divider: pulses tick for one cycle each time the
// count wraps from CLK_DIVIDE-1 back to 0.
module sample_rate_ticker #(
  parameter int CLK_DIVIDE = 1134
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;

  logic [CW-1:0] r_count;
  logic          r_tick;

  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == CW'(CLK_DIVIDE - 1)) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + CW'(1);
      r_tick  <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces the SPI DAC at the audio sample rate: picks one enabled source per tick,
// runs the DAC send handshake and tracks underruns and handshake timeouts.
module dac_sample_scheduler
  import music_box_pkg::*;
#(
  parameter int                     CLK_DIVIDE     = 1134,
  parameter int                     SAMPLE_BITS    = 12,
  parameter int                     NUM_SOURCES    = 4,
  parameter logic [SAMPLE_BITS-1:0] MIDSCALE       = DAC_MIDSCALE,
  parameter int                     TIMEOUT_CYCLES = 4096
) (
  input  logic                                    clock_50Mhz,
  input  logic                                    reset_n,
  input  logic [4:0]                              currentState,
  input  logic [NUM_SOURCES-1:0]                  source_valid,
  input  logic [NUM_SOURCES-1:0][SAMPLE_BITS-1:0] source_sample,
  output logic [NUM_SOURCES-1:0]                  source_ready,
  input  logic                                    dac_isBusy,
  input  logic                                    dac_transmitComplete,
  output logic [SAMPLE_BITS-1:0]                  dac_inputSample,
  output logic                                    dac_sendSample_n,
  output logic                                    sampleTick,
  output logic [15:0]                             underrunCount,
  output logic                                    timeoutError
);

  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  dac_sched_state_t r_state, w_nextState;

  logic                   w_tick;
  logic                   r_pending;
  logic                   r_busyPrev;
  logic [TW-1:0]          r_toCount;
  logic [SAMPLE_BITS-1:0] r_sample;
  logic [15:0]            r_underrun;
  logic                   r_timeout;

  logic [NUM_SOURCES-1:0] w_enable;
  logic [NUM_SOURCES-1:0] w_request;
  logic                   w_found;
  logic [IW-1:0]          w_winnerIdx;
  logic                   w_toExpired;
  logic                   w_sendSample_n;
  logic [NUM_SOURCES-1:0] w_ready;

  sample_rate_ticker #(
    .CLK_DIVIDE (CLK_DIVIDE)
  ) u_ticker (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .tick        (w_tick)
  );

  assign w_enable  = sourceMask(currentState);
  assign w_request = w_enable & source_valid;

  // Descending scan so the lowest requesting index is the one left standing.
  always_comb begin
    w_found     = 1'b0;
    w_winnerIdx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (w_request[i]) begin
        w_found     = 1'b1;
        w_winnerIdx = IW'(i);
      end
    end
  end

  assign w_toExpired = ((r_state == START) || (r_state == WAIT_DONE)) &&
                       (r_toCount == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_sendSample_n = 1'b1;
    w_ready        = '0;
    case (r_state)
      IDLE: begin
        if (w_tick || r_pending) w_nextState = SELECT;
      end
      SELECT: begin
        if (w_found) w_ready[w_winnerIdx] = 1'b1;
        w_nextState = START;
      end
      START: begin
        w_sendSample_n = 1'b0;
        if (w_toExpired)     w_nextState = IDLE;
        else if (dac_isBusy) w_nextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_toExpired || dac_transmitComplete || (r_busyPrev && !dac_isBusy))
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A tick that lands while a transfer is in flight is remembered once; extras are lost.
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      r_pending  <= 1'b0;
      r_busyPrev <= 1'b0;
      r_toCount  <= '0;
      r_sample   <= MIDSCALE;
      r_underrun <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_busyPrev <= dac_isBusy;

      if (r_state == IDLE)  r_pending <= 1'b0;
      else if (w_tick)      r_pending <= 1'b1;

      if (r_state == SELECT) begin
        r_toCount <= '0;
        if (w_found) begin
          r_sample <= source_sample[w_winnerIdx];
        end else begin
          r_sample <= MIDSCALE;
          if ((|w_enable) && (r_underrun != 16'hFFFF)) r_underrun <= r_underrun + 16'd1;
        end
      end else if ((r_state == START) || (r_state == WAIT_DONE)) begin
        r_toCount <= r_toCount + TW'(1);
      end

      if (w_toExpired) r_timeout <= 1'b1;
    end
  end

  assign source_ready     = w_ready;
  assign dac_inputSample  = r_sample;
  assign dac_sendSample_n = w_sendSample_n;
  assign sampleTick       = w_tick;
  assign underrunCount    = r_underrun;
  assign timeoutError     = r_timeout;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: stimulus pushes the expected DAC sample
// and source_ready pulses, a monitor pops them as the DUT starts sends.
`timescale 1ns/1ps
module tb_dac_sample_scheduler;

  localparam int P  = 1134;
  localparam int TO = 4096;

  typedef struct {
    logic [11:0] sample;
    bit          chkLat;
  } sendExp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [4:0]      currentState;
  logic [3:0]      source_valid;
  logic [3:0][11:0] source_sample;
  logic [3:0]      source_ready;
  logic            dac_isBusy;
  logic            dac_transmitComplete;
  logic [11:0]     dac_inputSample;
  logic            dac_sendSample_n;
  logic            sampleTick;
  logic [15:0]     underrunCount;
  logic            timeoutError;

  sendExp_t   sendQ[$];
  logic [3:0] readyQ[$];

  int total = 0;
  int bad   = 0;
  int modelEdge = 0;
  int expUnderrun = 0;
  bit expTimeout = 1'b0;
  int busyLen = 30;
  bit dacMode = 1'b1;
  int busyLeft = 0;
  bit prevSend = 1'b1;
  bit prevReady = 1'b0;

  always #10 clk = ~clk;

  dac_sample_scheduler dut (
    .clock_50Mhz          (clk),
    .reset_n              (reset_n),
    .currentState         (currentState),
    .source_valid         (source_valid),
    .source_sample        (source_sample),
    .source_ready         (source_ready),
    .dac_isBusy           (dac_isBusy),
    .dac_transmitComplete (dac_transmitComplete),
    .dac_inputSample      (dac_inputSample),
    .dac_sendSample_n     (dac_sendSample_n),
    .sampleTick           (sampleTick),
    .underrunCount        (underrunCount),
    .timeoutError         (timeoutError)
  );

  // Clock edges counted since the last reset edge; a tick is due every P of them.
  always @(posedge clk) begin
    if (!reset_n) modelEdge <= 0;
    else          modelEdge <= modelEdge + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, modelEdge);
    end
  endtask

  task automatic reportMissing(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: DUT output with no expectation queued (edge %0d)", name, modelEdge);
  endtask

  function automatic int enabledSource(input logic [4:0] st);
    case (st)
      5'd1, 5'd4: return 0;
      5'd2:       return 1;
      5'd3:       return 2;
      5'd5:       return 3;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [47:0] randomSamples();
    logic [3:0][11:0] s;
    for (int i = 0; i < 4; i++) s[i] = 12'($urandom);
    return s;
  endfunction

  task automatic applyStimulus(input logic [4:0] st, input logic [3:0] valid,
                               input logic [3:0][11:0] samples, input bit chkLat);
    int src;
    sendExp_t e;
    currentState  = st;
    source_valid  = valid;
    source_sample = samples;
    src = enabledSource(st);
    e.chkLat = chkLat;
    if (src >= 0 && valid[src]) begin
      e.sample = samples[src];
      readyQ.push_back(4'b0001 << src);
    end else begin
      e.sample = 12'h800;
      if (src >= 0 && expUnderrun < 65535) expUnderrun++;
    end
    sendQ.push_back(e);
  endtask

  task automatic waitEdge(input int target);
    int guard;
    guard = 0;
    while (modelEdge < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (modelEdge < target) checkOutput("waitBound", modelEdge, target);
  endtask

  task automatic runTick(input int k, input logic [4:0] st, input logic [3:0] valid,
                         input logic [3:0][11:0] samples);
    waitEdge(k * P - 50);
    applyStimulus(st, valid, samples, 1'b1);
    waitEdge(k * P + 100);
    checkOutput("underrunCount", underrunCount, expUnderrun);
    checkOutput("idleSendHigh", dac_sendSample_n, 1);
    checkOutput("timeoutError", timeoutError, expTimeout);
  endtask

  // Simple SPI DAC stand-in: raises isBusy for busyLen cycles after a send request.
  initial begin
    dac_isBusy = 1'b0;
    dac_transmitComplete = 1'b0;
    forever begin
      @(negedge clk);
      dac_transmitComplete = 1'b0;
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          dac_isBusy = 1'b0;
          dac_transmitComplete = 1'b1;
        end
      end else if (dacMode && dac_sendSample_n === 1'b0) begin
        dac_isBusy = 1'b1;
        busyLeft = busyLen;
      end
    end
  end

  always @(negedge clk) begin
    sendExp_t e;
    bit expTick;
    expTick = (modelEdge > 0) && (modelEdge % P == 0);
    if (expTick || sampleTick !== 1'b0) checkOutput("sampleTick", sampleTick, expTick);

    if (prevSend && dac_sendSample_n === 1'b0) begin
      if (sendQ.size() == 0) begin
        reportMissing("unexpectedSend");
      end else begin
        e = sendQ.pop_front();
        checkOutput("inputSample", dac_inputSample, e.sample);
        if (e.chkLat) checkOutput("sendLatency", modelEdge % P, 2);
      end
    end
    prevSend = (dac_sendSample_n !== 1'b0);

    if (source_ready !== 4'b0000) begin
      if (prevReady) reportMissing("readyPulseWidth");
      if (readyQ.size() == 0) reportMissing("unexpectedReady");
      else checkOutput("sourceReady", source_ready, readyQ.pop_front());
      prevReady = 1'b1;
    end else begin
      prevReady = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][11:0] smp;
    logic [3:0] vld;
    reset_n       = 1'b0;
    currentState  = 5'd0;
    source_valid  = 4'b0000;
    source_sample = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstSendN", dac_sendSample_n, 1);
    checkOutput("rstInputSample", dac_inputSample, 12'h800);
    checkOutput("rstReady", source_ready, 0);
    checkOutput("rstTick", sampleTick, 0);
    checkOutput("rstUnderrun", underrunCount, 0);
    checkOutput("rstTimeout", timeoutError, 0);
    reset_n = 1'b1;

    smp = randomSamples();
    smp[1] = 12'hABC;
    runTick(1, 5'd2, 4'b0010, smp);
    runTick(2, 5'd1, 4'b0011, randomSamples());
    for (int k = 3; k <= 5; k++) runTick(k, 5'd3, 4'($urandom) & 4'b1011, randomSamples());
    for (int k = 6; k <= 7; k++) runTick(k, 5'd0, 4'($urandom), randomSamples());
    for (int k = 8; k <= 27; k++)
      runTick(k, 5'($urandom_range(0, 7)), 4'($urandom), randomSamples());

    // DAC never answers: first send times out, pending ticks force an immediate retry.
    waitEdge(28 * P - 50);
    dacMode = 1'b0;
    smp = randomSamples();
    vld = 4'($urandom) | 4'b0010;
    applyStimulus(5'd2, vld, smp, 1'b1);
    applyStimulus(5'd2, vld, smp, 1'b0);
    waitEdge(28 * P + 2 + TO - 1);
    checkOutput("timeoutNotYet", timeoutError, 0);
    checkOutput("sendHeldLow", dac_sendSample_n, 0);
    waitEdge(28 * P + 2 + TO);
    checkOutput("timeoutSet", timeoutError, 1);
    checkOutput("sendAfterTimeout", dac_sendSample_n, 1);
    dacMode = 1'b1;
    expTimeout = 1'b1;
    runTick(32, 5'($urandom_range(0, 7)), 4'($urandom), randomSamples());

    // Transfer spanning two tick periods: one retry, the second missed tick is lost.
    waitEdge(33 * P - 50);
    busyLen = 2400;
    smp = randomSamples();
    applyStimulus(5'd3, 4'b0100, smp, 1'b1);
    waitEdge(33 * P + 5);
    busyLen = 30;
    waitEdge(33 * P + 1200);
    smp[2] = smp[2] ^ 12'hFFF;
    applyStimulus(5'd3, 4'b0100, smp, 1'b0);
    waitEdge(33 * P + 2500);
    checkOutput("longBusyQueueDrained", sendQ.size(), 0);
    checkOutput("longBusyUnderrun", underrunCount, expUnderrun);

    // Reset in the middle of WAIT_DONE.
    waitEdge(36 * P - 50);
    smp = randomSamples();
    applyStimulus(5'd5, 4'($urandom) | 4'b1000, smp, 1'b1);
    waitEdge(36 * P + 12);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midRstSendN", dac_sendSample_n, 1);
    checkOutput("midRstInputSample", dac_inputSample, 12'h800);
    checkOutput("midRstUnderrun", underrunCount, 0);
    checkOutput("midRstTimeout", timeoutError, 0);
    checkOutput("midRstReady", source_ready, 0);
    expUnderrun = 0;
    expTimeout  = 1'b0;
    for (int k = 1; k <= 3; k++)
      runTick(k, 5'($urandom_range(0, 7)), 4'($urandom), randomSamples());

    checkOutput("sendQueueEmpty", sendQ.size(), 0);
    checkOutput("readyQueueEmpty", readyQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
